// File: rtl/dm_bus_controller.sv
// dm_bus_controller: MEM-stage data-memory responder.
// Serves pipeline loads/stores from the external asynchronous SRAM (RAM1) and
// the UART sharing the RAM1 data bus, stalling the pipeline through memBusy
// while a multi-cycle access is in flight.
module dm_bus_controller #(
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] Address,
  input  logic [15:0] WriteData,
  output logic [15:0] ReadData,
  output logic        memBusy,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  typedef enum logic [2:0] {
    IDLE,
    SRAM_RD,
    SRAM_WR,
    UART_RD,
    UART_WR,
    DONE
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        drive_q, drive_d;
  logic        en_n_q, oe_n_q, we_n_q, rdn_q, wrn_n_q;
  logic        req;
  logic        prev_is_wr;

  assign req        = MemRead | MemWrite;
  assign prev_is_wr = (state_q == SRAM_WR) || (state_q == UART_WR);

  // Next-state, counter and data-path register computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = '0;
          if (Address == UART_DATA_ADDR) begin
            wdata_d = WriteData;
            state_d = MemWrite ? UART_WR : UART_RD;
          end else if (Address == UART_STAT_ADDR) begin
            // Status reads finish in the decode cycle; status writes are dropped.
            if (!MemWrite) begin
              rdata_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
            end
            state_d = DONE;
          end else begin
            addr_d  = {2'b00, Address};
            wdata_d = WriteData;
            state_d = MemWrite ? SRAM_WR : SRAM_RD;
          end
        end
      end
      SRAM_RD: begin
        if (cnt_q == WAIT_LAST) begin
          rdata_d = ram_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SRAM_WR: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      UART_RD: begin
        if (cnt_q == 3'd1) begin
          rdata_d = {8'b0, ram_data[7:0]};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      UART_WR: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus drive continues through the DONE that follows a write for data hold.
  always_comb begin
    drive_d = (state_d == SRAM_WR) || (state_d == UART_WR) ||
              ((state_d == DONE) && prev_is_wr);
  end

  // State register with strobes registered from the next state so they are
  // glitch-free and track the state exactly; reset drops them immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      en_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      drive_q <= drive_d;
      en_n_q  <= !((state_d == SRAM_RD) || (state_d == SRAM_WR));
      oe_n_q  <= !(state_d == SRAM_RD);
      we_n_q  <= !(state_d == SRAM_WR);
      rdn_q   <= !(state_d == UART_RD);
      wrn_n_q <= !(state_d == UART_WR);
    end
  end

  // Stall request: decode cycle with a pending request plus every strobe state.
  always_comb begin
    memBusy = rst && (((state_q == IDLE) && req) ||
                      (state_q == SRAM_RD) || (state_q == SRAM_WR) ||
                      (state_q == UART_RD) || (state_q == UART_WR));
  end

  assign ram_data = drive_q ? wdata_q : 16'hzzzz;
  assign ReadData = rdata_q;
  assign ram_addr = addr_q;
  assign ram_en_n = en_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign uart_rdn = rdn_q;
  assign uart_wrn = wrn_n_q;

endmodule
